div_unit: RTL and testbench

Iterative radix-2 integer divider for the execute stage, downstream of the ALU-control decoder. It consumes the decoded DIV/DIVU operation, computes quotient and remainder over 32 cycles, and holds the pipeline stalled until the result is ready. The results are written into the HI/LO path: quotient to LO, remainder to HI. Signed division follows MIPS conventions: the quotient truncates toward zero and the remainder takes the sign of the dividend.

---
 rtl/div_unit.sv | 201 ++++++++++++++++++++
 tb/tb_div_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit -- iterative radix-2 restoring integer divider (DIV / DIVU).
//
// Produces quotient (lo_o) and remainder (hi_o) after WIDTH restoring steps.
// Signed results truncate toward zero and the remainder takes the dividend's
// sign. A zero divisor is not trapped: the magnitude quotient is all-ones,
// the magnitude remainder is |a|, and dz_o is raised with the strobe.
//
// Optional build macro:
//   DIV_ZERO_FAST_EN  zero divisor goes straight from IDLE to DONE
//                     (result strobe one cycle after start).
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   start       division request, sampled in IDLE only
//   signed_div  1 = signed (DIV), 0 = unsigned (DIVU), sampled with start
//   a, b        dividend / divisor, sampled with start
//   annul       aborts an operation in BUSY
//   stall_o     combinational pipeline hold
//   valid_o     one-cycle result strobe (registered)
//   lo_o        quotient (registered, held until next result or reset)
//   hi_o        remainder (registered, held until next result or reset)
//   dz_o        divisor was zero, qualified by valid_o
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; operands latched on acceptance
// BUSY  | one restoring step per cycle, counter 0..WIDTH-1
// DONE  | result registers hold the fresh result, valid_o high this cycle

module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             annul,
  output logic             stall_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             dz_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic             qneg_in, rneg_in;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] sub_w;
  logic             ge;
  logic [WIDTH-1:0] rem_step, quo_step;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic neg);
    cond_neg = neg ? (~v + WIDTH'(1)) : v;
  endfunction

  // Operand magnitudes and result signs at acceptance.
  always_comb begin
    abs_a   = cond_neg(a, signed_div & a[WIDTH-1]);
    abs_b   = cond_neg(b, signed_div & b[WIDTH-1]);
    qneg_in = (a[WIDTH-1] ^ b[WIDTH-1]) & signed_div;
    rneg_in = a[WIDTH-1] & signed_div;
  end

  // One restoring step. The trial value is WIDTH+1 bits; when it is not
  // below the divisor the true difference is smaller than the divisor, so a
  // WIDTH-bit modular subtract gives it exactly.
  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    ge       = (shifted >= {1'b0, dvs_q});
    sub_w    = shifted[WIDTH-1:0] - dvs_q;
    rem_step = ge ? sub_w : shifted[WIDTH-1:0];
    quo_step = {quo_q[WIDTH-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    valid_d = 1'b0;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dz_d    = dz_q;

    case (state_q)
      S_IDLE: begin
        if (start && !annul) begin
          dvs_d  = abs_b;
          qneg_d = qneg_in;
          rneg_d = rneg_in;
          rem_d  = '0;
          quo_d  = abs_a;
          cnt_d  = '0;
`ifdef DIV_ZERO_FAST_EN
          if (abs_b == '0) begin
            state_d = S_DONE;
            valid_d = 1'b1;
            lo_d    = cond_neg({WIDTH{1'b1}}, qneg_in);
            hi_d    = cond_neg(abs_a, rneg_in);
            dz_d    = 1'b1;
          end else begin
            state_d = S_BUSY;
          end
`else
          state_d = S_BUSY;
`endif
        end
      end

      S_BUSY: begin
        if (annul) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + CW'(1);
          // Results are registered on the way into DONE so that valid_o and
          // the data are visible during the DONE cycle itself.
          if (cnt_q == CNT_LAST) begin
            state_d = S_DONE;
            valid_d = 1'b1;
            lo_d    = cond_neg(quo_step, qneg_q);
            hi_d    = cond_neg(rem_step, rneg_q);
            dz_d    = (dvs_q == '0);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      valid_q <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      valid_q <= valid_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      dz_q    <= dz_d;
    end
  end

  assign stall_o = ((state_q == S_IDLE) & start & ~annul) | (state_q == S_BUSY);
  assign valid_o = valid_q;
  assign lo_o    = lo_q;
  assign hi_o    = hi_q;
  assign dz_o    = dz_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit -- self-checking bench for div_unit (WIDTH = 32).
// Directed cases followed by randomized operands, compared against a
// 64-bit arithmetic reference model.

module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        annul;
  logic        stall_o;
  logic        valid_o;
  logic [31:0] lo_o;
  logic [31:0] hi_o;
  logic        dz_o;

  int npass = 0;
  int ntot  = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .a          (a),
    .b          (b),
    .annul      (annul),
    .stall_o    (stall_o),
    .valid_o    (valid_o),
    .lo_o       (lo_o),
    .hi_o       (hi_o),
    .dz_o       (dz_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: plain 64-bit signed arithmetic (truncating division, remainder
  // with dividend's sign); zero divisor gives all-ones / |a| magnitudes.
  task automatic model(input logic [31:0] av, input logic [31:0] bv, input bit sg,
                       output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa, sb, qq, rr;
    sa = sg ? longint'($signed(av)) : longint'({32'b0, av});
    sb = sg ? longint'($signed(bv)) : longint'({32'b0, bv});
    if (sb == 0) begin
      dz = 1'b1;
      qq = (sa < 0) ? -longint'(64'hFFFF_FFFF) : longint'(64'hFFFF_FFFF);
      rr = sa;
    end else begin
      dz = 1'b0;
      qq = sa / sb;
      rr = sa % sb;
    end
    q = qq[31:0];
    r = rr[31:0];
  endtask

  function automatic int exp_latency(input logic [31:0] bv);
`ifdef DIV_ZERO_FAST_EN
    return (bv == 32'd0) ? 1 : 33;
`else
    return 33;
`endif
  endfunction

  task automatic run_div(input logic [31:0] av, input logic [31:0] bv, input bit sg,
                         input string tag);
    logic [31:0] eq, er;
    logic        ed;
    int          k;
    bit          stall_ok, got;
    model(av, bv, sg, eq, er, ed);
    @(negedge clk);
    start = 1'b1; a = av; b = bv; signed_div = sg;
    #1 chk({tag, ".stall_T"}, 64'(stall_o), 64'd1);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; signed_div = ~sg;
    k = 1; stall_ok = 1'b1; got = 1'b0;
    while (k <= 40) begin
      if (valid_o) begin
        got = 1'b1;
        break;
      end
      if (!stall_o) stall_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    chk({tag, ".latency"}, got ? 64'(k) : 64'hDEAD, 64'(exp_latency(bv)));
    chk({tag, ".stall_busy"}, 64'(stall_ok), 64'd1);
    chk({tag, ".stall_done"}, 64'(stall_o), 64'd0);
    chk({tag, ".lo"}, 64'(lo_o), 64'(eq));
    chk({tag, ".hi"}, 64'(hi_o), 64'(er));
    chk({tag, ".dz"}, 64'(dz_o), 64'(ed));
    @(negedge clk);
    chk({tag, ".strobe_1cyc"}, 64'(valid_o), 64'd0);
    chk({tag, ".lo_hold"}, 64'(lo_o), 64'(eq));
  endtask

  task automatic watch_no_valid(input string tag);
    bit seen;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (valid_o) seen = 1'b1;
    end
    chk({tag, ".no_strobe"}, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [31:0] plo, phi;
    logic        pdz;
    logic [31:0] ra, rb;
    bit          rs;

    rst = 1'b1; start = 1'b0; signed_div = 1'b0; a = '0; b = '0; annul = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset.valid", 64'(valid_o), 64'd0);
    chk("reset.lo", 64'(lo_o), 64'd0);
    chk("reset.hi", 64'(hi_o), 64'd0);
    chk("reset.dz", 64'(dz_o), 64'd0);
    chk("reset.stall", 64'(stall_o), 64'd0);

    run_div(32'd100, 32'd7, 1'b0, "u100_7");
    chk("u100_7.lo_const", 64'(lo_o), 64'd14);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "s-7_2");
    chk("s-7_2.lo_const", 64'(lo_o), 64'hFFFF_FFFD);
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, "s7_-2");
    chk("s7_-2.hi_const", 64'(hi_o), 64'd1);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_ovf");
    chk("s_ovf.lo_const", 64'(lo_o), 64'h8000_0000);
    run_div(32'd5, 32'd0, 1'b1, "s5_0");
    chk("s5_0.lo_const", 64'(lo_o), 64'hFFFF_FFFF);
    run_div(32'hFFFF_FFFB, 32'd0, 1'b1, "s-5_0");
    run_div(32'hFFFF_FFFB, 32'd0, 1'b0, "u_big_0");

    // Annul during BUSY at T+10.
    plo = lo_o; phi = hi_o; pdz = dz_o;
    @(negedge clk);
    start = 1'b1; a = 32'd100; b = 32'd7; signed_div = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    #1;
    chk("annul.stall_T11", 64'(stall_o), 64'd0);
    chk("annul.valid_T11", 64'(valid_o), 64'd0);
    watch_no_valid("annul");
    chk("annul.lo_kept", 64'(lo_o), 64'(plo));
    chk("annul.hi_kept", 64'(hi_o), 64'(phi));
    chk("annul.dz_kept", 64'(dz_o), 64'(pdz));
    run_div(32'd9, 32'd3, 1'b0, "after_annul_9_3");

    // start held through BUSY is ignored; annul in DONE does not cancel.
    @(negedge clk);
    start = 1'b1; a = 32'd1000; b = 32'd9; signed_div = 1'b0;
    @(negedge clk);
    a = 32'd55; b = 32'd5;
    repeat (31) @(negedge clk);
    #1 chk("done_annul.stall_T32", 64'(stall_o), 64'd1);
    @(negedge clk);
    start = 1'b0; annul = 1'b1;
    #1;
    chk("done_annul.valid", 64'(valid_o), 64'd1);
    chk("done_annul.lo", 64'(lo_o), 64'd111);
    chk("done_annul.hi", 64'(hi_o), 64'd1);
    @(negedge clk);
    annul = 1'b0;
    #1;
    chk("done_annul.valid_off", 64'(valid_o), 64'd0);
    chk("done_annul.idle_no_stall", 64'(stall_o), 64'd0);

    // Reset at T+20 with start raised during the reset cycle.
    @(negedge clk);
    start = 1'b1; a = 32'd77; b = 32'd4; signed_div = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 32'd9; b = 32'd3;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    #1;
    chk("midrst.lo", 64'(lo_o), 64'd0);
    chk("midrst.hi", 64'(hi_o), 64'd0);
    chk("midrst.dz", 64'(dz_o), 64'd0);
    chk("midrst.valid", 64'(valid_o), 64'd0);
    chk("midrst.stall", 64'(stall_o), 64'd0);
    watch_no_valid("midrst");
    run_div(32'd9, 32'd3, 1'b0, "after_rst_9_3");

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = -32'($urandom_range(1, 15));
        3:       rb = ra >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      run_div(ra, rb, rs, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
